// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side execution unit.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rezultat;
    } instruction_t;

endpackage

// File: rtl/instr_exec_if.sv
// Bus between the execution unit (slave) and whoever drives runs and drains results (master).
interface instr_exec_if;
    import instr_register_pkg::*;

    // Result beats: a beat transfers on a rising edge where res_valid && res_ready;
    // res_valid never depends on res_ready, and all res_* stay stable while valid is unaccepted.
    logic         start;
    address_t     first_addr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready;
    address_t     res_addr;
    opcode_t      res_opc;
    result_t      res_value;
    logic         res_err;
    logic         busy;
    logic         done;
    logic [2:0]   dbg_state;

    modport slave (
        input  start, first_addr, count, instruction_word, res_ready,
        output read_pointer, res_valid, res_addr, res_opc, res_value, res_err,
               busy, done, dbg_state
    );

    modport master (
        output start, first_addr, count, instruction_word, res_ready,
        input  read_pointer, res_valid, res_addr, res_opc, res_value, res_err,
               busy, done, dbg_state
    );

endinterface

// File: rtl/instr_exec_unit.sv
// Walks read_pointer over a slot range, executes each instruction and streams
// the 64-bit results out over a valid/ready handshake.
module instr_exec_unit
    import instr_register_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    instr_exec_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state, state_next;
    address_t   addr_q;
    logic [5:0] remaining;
    opcode_t    opc_q;
    operand_t   a_q, b_q;
    result_t    a64, b64;
    result_t    exec_value;
    logic       exec_err;
    logic       handshake;

    // The stored result field is not consumed on the read side.
    wire unused_rezultat = ^bus.instruction_word.rezultat;

    assign handshake     = bus.res_valid && bus.res_ready;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.dbg_state = state;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = (bus.count == 6'd0) ? S_DONE : S_FETCH;
            S_FETCH: state_next = S_EXEC;
            S_EXEC:  state_next = S_OUT;
            S_OUT:   if (handshake) state_next = (remaining > 6'd1) ? S_FETCH : S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Sign-extend first so -2^31 / -1 and (-2^31)^2 are exact in 64 bits.
    always_comb begin
        a64        = {{32{a_q[31]}}, a_q};
        b64        = {{32{b_q[31]}}, b_q};
        exec_value = '0;
        exec_err   = 1'b0;
        case (opc_q)
            ZERO:  exec_value = '0;
            PASSA: exec_value = a64;
            PASSB: exec_value = b64;
            ADD:   exec_value = a64 + b64;
            SUB:   exec_value = a64 - b64;
            MULT:  exec_value = a64 * b64;
            DIV: begin
                if (b_q == '0) exec_err = 1'b1;
                else           exec_value = a64 / b64;
            end
            MOD: begin
                if (b_q == '0) exec_err = 1'b1;
                else           exec_value = a64 % b64;
            end
            default: exec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            addr_q           <= '0;
            remaining        <= '0;
            opc_q            <= ZERO;
            a_q              <= '0;
            b_q              <= '0;
            bus.read_pointer <= '0;
            bus.res_valid    <= 1'b0;
            bus.res_addr     <= '0;
            bus.res_opc      <= ZERO;
            bus.res_value    <= '0;
            bus.res_err      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        addr_q    <= bus.first_addr;
                        remaining <= bus.count;
                        if (bus.count != 6'd0) bus.read_pointer <= bus.first_addr;
                    end
                end
                S_FETCH: begin
                    opc_q <= bus.instruction_word.opc;
                    a_q   <= bus.instruction_word.op_a;
                    b_q   <= bus.instruction_word.op_b;
                end
                S_EXEC: begin
                    bus.res_value <= exec_value;
                    bus.res_err   <= exec_err;
                    bus.res_opc   <= opc_q;
                    bus.res_addr  <= addr_q;
                    bus.res_valid <= 1'b1;
                end
                S_OUT: begin
                    if (handshake) begin
                        bus.res_valid <= 1'b0;
                        remaining     <= remaining - 6'd1;
                        // Address wraps 31 -> 0 through the natural 5-bit overflow.
                        if (remaining > 6'd1) begin
                            addr_q           <= addr_q + 5'd1;
                            bus.read_pointer <= addr_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
